// File: rtl/ahblite_keypad.sv
// rtl/ahblite_keypad.sv - AHB-Lite 4x4 keypad scanner with debounce and last-key register
module ahblite_keypad #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [3:0]  key_col,
  input  logic [3:0]  key_row,
  output logic        key_irq
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);
  localparam logic [4:0] NONE = 5'h10;

  typedef enum logic {IDLE, PRESSED} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [4:0]    col_code, frame_acc, frame_res, cand;
  logic [3:0]    cnt, cnt_upd;
  logic          tick, frame_end, capture;
  state_t        state, state_nxt;
  logic          dp_we, dp_rd, bus_cap, clr;
  logic [1:0]    dp_sel;
  logic [3:0]    code;
  logic          valid, overrun;
  logic          unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = ^{HSIZE, HWDATA, HADDR[31:4], HADDR[1:0]};

  assign bus_cap = HSEL & HTRANS[1] & HREADY;
  assign clr     = dp_we && (dp_sel == 2'd1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_we  <= 1'b0;
      dp_rd  <= 1'b0;
      dp_sel <= 2'd0;
    end else begin
      dp_we  <= bus_cap & HWRITE;
      dp_rd  <= bus_cap & ~HWRITE;
      dp_sel <= bus_cap ? HADDR[3:2] : 2'd0;
    end
  end

  assign HRDATA  = (dp_rd && dp_sel == 2'd0) ? {26'd0, overrun, valid, code} : 32'd0;
  assign key_irq = valid;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  assign key_col   = ~(4'b0001 << col_idx);
  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (col_idx == 2'd3);

  // Lowest pressed row in the driven column gives the lowest code for that column.
  always_comb begin
    col_code = NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) col_code = {1'b0, 2'(r), col_idx};
    end
  end

  assign frame_res = (col_code < frame_acc) ? col_code : frame_acc;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      frame_acc <= NONE;
    end else if (tick) begin
      div_cnt   <= '0;
      col_idx   <= col_idx + 2'd1;
      frame_acc <= (col_idx == 2'd0) ? col_code : frame_res;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign cnt_upd = (frame_res != cand) ? 4'd1 : ((cnt >= DEB) ? DEB : cnt + 4'd1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cand <= NONE;
      cnt  <= 4'd0;
    end else if (frame_end) begin
      cand <= frame_res;
      cnt  <= cnt_upd;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_end && cnt_upd == DEB) begin
      case (state)
        IDLE:    if (frame_res != NONE) state_nxt = PRESSED;
        PRESSED: if (frame_res == NONE) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    capture = (state == IDLE) && (state_nxt == PRESSED);
  end

  // A capture coinciding with a clear keeps the new key but drops the overrun.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      code    <= 4'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (capture) begin
      code    <= frame_res[3:0];
      valid   <= 1'b1;
      overrun <= clr ? 1'b0 : (overrun | valid);
    end else if (clr) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ahblite_keypad.sv
// tb/tb_ahblite_keypad.sv - randomized frame-level bench for ahblite_keypad
module tb_ahblite_keypad;
  localparam int SCAN_DIV = 4;
  localparam int DEB = 2;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP, key_irq;
  logic [31:0] HRDATA;
  logic [3:0]  key_col, key_row;
  logic [15:0] keys;

  int n_pass = 0;
  int n_total = 0;

  int         hist[$];
  logic       m_held, m_valid, m_ov;
  logic [3:0] m_code;

  ahblite_keypad #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .key_col(key_col), .key_row(key_row), .key_irq(key_irq)
  );

  always #5 HCLK = ~HCLK;

  // Passive keypad: a pressed key shorts its row to its column.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[r*4 +: 4] & ~key_col)) key_row[r] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic m_reset();
    hist.delete();
    m_held = 1'b0; m_valid = 1'b0; m_ov = 1'b0; m_code = 4'd0;
  endtask

  task automatic m_clear();
    m_valid = 1'b0; m_ov = 1'b0;
  endtask

  // A key state is accepted once the last DEB frames all saw the same lowest key.
  task automatic m_frame(input logic [15:0] k);
    int  res;
    bit  stable;
    res = 16;
    for (int i = 15; i >= 0; i--) if (k[i]) res = i;
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != res) stable = 0;
    if (stable && res != 16 && !m_held) begin
      m_held  = 1'b1;
      m_ov    = m_ov | m_valid;
      m_valid = 1'b1;
      m_code  = 4'(res);
    end else if (stable && res == 16) begin
      m_held = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    return (a == 2'd0) ? {26'd0, m_ov, m_valid, m_code} : 32'd0;
  endfunction

  task automatic bus_addr(input logic [1:0] a, input logic w);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = {28'h4000000, a, 2'b00};
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    bus_idle();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    m_reset();
  endtask

  // One scan frame starting right after a frame boundary: read at the start,
  // optional back-to-back write + read, optional clear landing on the frame end.
  task automatic frame(input logic [15:0] k, input logic [1:0] raddr, input bit wr,
                       input logic [1:0] waddr, input bit clr_end, input bit chk_col);
    int n;
    logic [3:0] ec;
    keys = k;
    n = 0;
    bus_addr(raddr, 1'b0);
    @(posedge HCLK); n++; @(negedge HCLK);
    if (wr) bus_addr(waddr, 1'b1); else bus_idle();
    check("rdata", HRDATA, exp_rd(raddr));
    check("irq", {31'd0, key_irq}, {31'd0, m_valid});
    if (wr) begin
      @(posedge HCLK); n++; @(negedge HCLK);
      HWDATA = $urandom;
      bus_addr(2'd0, 1'b0);
      @(posedge HCLK); n++; @(negedge HCLK);
      bus_idle();
      if (waddr == 2'd1) m_clear();
      check("rdata_after_wr", HRDATA, exp_rd(2'd0));
      check("irq_after_wr", {31'd0, key_irq}, {31'd0, m_valid});
    end
    while (n < 16) begin
      if (chk_col) begin
        ec = ~(4'b0001 << (n / 4));
        check("key_col", {28'd0, key_col}, {28'd0, ec});
      end
      if (clr_end && n == 14) bus_addr(2'd1, 1'b1);
      if (clr_end && n == 15) begin
        bus_idle();
        HWDATA = $urandom;
      end
      @(posedge HCLK); n++; @(negedge HCLK);
    end
    if (clr_end) m_clear();
    m_frame(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] k;
    bit          wr, ce;
    logic [1:0]  ra, wa;
    HRESET = 1'b1; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = 32'd0;
    HADDR = 32'd0; keys = 16'd0;
    bus_idle();
    m_reset();
    @(negedge HCLK);
    do_reset();
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    frame(16'h0000, 2'd0, 0, 2'd0, 0, 1);

    repeat (2) frame(16'h0200, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0200, 2'd0, 1, 2'd1, 0, 0);
    repeat (2) frame(16'h0000, 2'd1, 0, 2'd0, 0, 0);

    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h0001 : 16'h0000, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0001, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0001, 2'd0, 1, 2'd1, 0, 0);
    repeat (2) frame(16'h0000, 2'd0, 0, 2'd0, 0, 0);

    repeat (2) frame(16'h0020, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0000, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0400, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0000, 2'd0, 1, 2'd1, 0, 0);
    frame(16'h0000, 2'd0, 0, 2'd0, 0, 0);

    repeat (2) frame(16'h1008, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0080, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0080, 2'd0, 1, 2'd1, 0, 0);
    frame(16'h0080, 2'd0, 1, 2'd2, 0, 0);

    repeat (2) frame(16'h0000, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0004, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) frame(16'h0000, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0040, 2'd0, 0, 2'd0, 0, 0);
    frame(16'h0040, 2'd0, 0, 2'd0, 1, 0);
    frame(16'h0040, 2'd0, 0, 2'd0, 0, 0);

    keys = 16'h0002;
    repeat (7) @(posedge HCLK);
    @(negedge HCLK);
    do_reset();
    frame(16'h0002, 2'd0, 0, 2'd0, 0, 1);
    repeat (2) frame(16'h0002, 2'd0, 0, 2'd0, 0, 0);

    k = 16'h0000;
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 3))
        0, 1: k = k;
        2:    k = 16'h0000;
        default: k = ($urandom_range(0, 1) == 0) ? (16'h0001 << $urandom_range(0, 15))
                                                : 16'($urandom);
      endcase
      wr = ($urandom_range(0, 3) == 0);
      wa = 2'($urandom_range(1, 3));
      ce = !wr && ($urandom_range(0, 7) == 0);
      ra = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      frame(k, ra, wr, wa, ce, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
